// File: rtl/hog_sos_window_gen.sv
// HOG sum-of-squares window generator: per-cell SOS accumulation, two row buffers and a 3x3 sliding window.
// Define SOS_SAT_EN to saturate squares and sums at 2^TOTAL_BIT_WIDTH-1 instead of wrapping.
module hog_sos_window_gen #(
    parameter int QN              = 8,
    parameter int TOTAL_BIT_WIDTH = 35,
    parameter int LANES           = 4,
    parameter int MAX_COLS        = 64,
    localparam int COL_AW         = $clog2(MAX_COLS) + 1
) (
    input  logic                           aclk,
    input  logic                           arest,
    input  logic                           start,
    input  logic [COL_AW-1:0]              cfg_cols,
    input  logic [7:0]                     cfg_rows,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [LANES*TOTAL_BIT_WIDTH-1:0] s_data,
    input  logic [LANES-1:0]               s_keep,
    input  logic                           s_last,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [9*TOTAL_BIT_WIDTH-1:0]   m_win,
    output logic                           m_last,
    output logic                           busy,
    output logic                           done,
    output logic                           cfg_err
);
    localparam int TW    = TOTAL_BIT_WIDTH;
    localparam int IDX_W = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
    localparam int LSW   = TW + $clog2(LANES) + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_DONE} state_t;

    state_t            state;
    logic [COL_AW-1:0] cols_q, col_cnt, in_col;
    logic [7:0]        rows_q, row_cnt, in_row;
    logic              sel;
    logic              sq_vld, sq_last;
    logic [TW-1:0]     sq_sum, acc;
    logic [TW-1:0]     win [9];
    logic [TW-1:0]     row_buf0 [MAX_COLS];
    logic [TW-1:0]     row_buf1 [MAX_COLS];

    logic              adv, accept, cell_done, emit, out_last, in_last_cell, cfg_ok;
    logic [TW-1:0]     x, sq, sq_next, acc_next, top_val, mid_val;
    logic [2*TW-1:0]   prod;
    logic [LSW-1:0]    lane_sum;
    logic [TW:0]       acc_wide;
    logic [IDX_W-1:0]  col_idx;

    // Beats and windows transfer on a rising edge with valid && ready high; a held
    // valid keeps its payload stable. The pipeline freezes while a window is stuck.
    assign adv     = !(m_valid && !m_ready);
    assign s_ready = (state == ST_RUN) && adv;
    assign accept  = s_valid && s_ready;

    assign cfg_ok = (cfg_cols >= COL_AW'(3)) && (cfg_cols <= COL_AW'(MAX_COLS)) && (cfg_rows >= 8'd3);
    assign in_last_cell = (in_row == rows_q - 8'd1) && (in_col == cols_q - COL_AW'(1));
    assign out_last     = (row_cnt == rows_q - 8'd1) && (col_cnt == cols_q - COL_AW'(1));
    assign cell_done    = adv && sq_vld && sq_last;
    assign emit         = cell_done && (row_cnt >= 8'd2) && (col_cnt >= COL_AW'(2));

    assign col_idx = col_cnt[IDX_W-1:0];
    assign top_val = sel ? row_buf1[col_idx] : row_buf0[col_idx];
    assign mid_val = sel ? row_buf0[col_idx] : row_buf1[col_idx];

    always_comb begin
        lane_sum = '0;
        x        = '0;
        prod     = '0;
        sq       = '0;
        for (int i = 0; i < LANES; i++) begin
            x    = s_data[i*TW +: TW];
            prod = {{TW{1'b0}}, x} * {{TW{1'b0}}, x};
`ifdef SOS_SAT_EN
            sq = (|(prod >> (TW + QN))) ? '1 : TW'(prod >> QN);
`else
            sq = TW'(prod >> QN);
`endif
            if (s_keep[i]) lane_sum = lane_sum + LSW'(sq);
        end
        acc_wide = {1'b0, acc} + {1'b0, sq_sum};
`ifdef SOS_SAT_EN
        sq_next  = (|(lane_sum >> TW)) ? '1 : TW'(lane_sum);
        acc_next = acc_wide[TW] ? '1 : TW'(acc_wide);
`else
        sq_next  = TW'(lane_sum);
        acc_next = TW'(acc_wide);
`endif
    end

    // The finishing cell overwrites the oldest row's slot right after it was read.
    always_ff @(posedge aclk) begin
        if (cell_done) begin
            if (sel) row_buf1[col_idx] <= acc_next;
            else     row_buf0[col_idx] <= acc_next;
        end
    end

    always_ff @(posedge aclk or posedge arest) begin
        if (arest) begin
            state   <= ST_IDLE;
            cols_q  <= '0;
            rows_q  <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
            in_col  <= '0;
            in_row  <= '0;
            sel     <= 1'b0;
            sq_vld  <= 1'b0;
            sq_last <= 1'b0;
            sq_sum  <= '0;
            acc     <= '0;
            m_valid <= 1'b0;
            m_win   <= '0;
            m_last  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cfg_err <= 1'b0;
            for (int i = 0; i < 9; i++) win[i] <= '0;
        end else begin
            cfg_err <= 1'b0;
            done    <= 1'b0;
            if (adv) begin
                sq_vld  <= accept;
                sq_last <= s_last;
                sq_sum  <= sq_next;
            end
            if (adv && sq_vld) acc <= sq_last ? '0 : acc_next;
            if (cell_done) begin
                win[0] <= win[1]; win[1] <= win[2]; win[2] <= top_val;
                win[3] <= win[4]; win[4] <= win[5]; win[5] <= mid_val;
                win[6] <= win[7]; win[7] <= win[8]; win[8] <= acc_next;
                if (col_cnt == cols_q - COL_AW'(1)) begin
                    col_cnt <= '0;
                    row_cnt <= row_cnt + 8'd1;
                    sel     <= ~sel;
                end else begin
                    col_cnt <= col_cnt + COL_AW'(1);
                end
            end
            if (emit) begin
                m_valid <= 1'b1;
                m_win   <= {acc_next, win[8], win[7], mid_val, win[5], win[4], top_val, win[2], win[1]};
                m_last  <= out_last;
            end else if (m_ready) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end
            if (accept && s_last) begin
                if (in_col == cols_q - COL_AW'(1)) begin
                    in_col <= '0;
                    in_row <= in_row + 8'd1;
                end else begin
                    in_col <= in_col + COL_AW'(1);
                end
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            state   <= ST_RUN;
                            busy    <= 1'b1;
                            cols_q  <= cfg_cols;
                            rows_q  <= cfg_rows;
                            col_cnt <= '0;
                            row_cnt <= '0;
                            in_col  <= '0;
                            in_row  <= '0;
                            sel     <= 1'b0;
                            acc     <= '0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                ST_RUN:   if (accept && s_last && in_last_cell) state <= ST_FLUSH;
                ST_FLUSH: begin
                    if (m_valid && m_ready && m_last) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default:  state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hog_sos_window_gen.sv
// Directed bench for hog_sos_window_gen: window values, latency, backpressure, config errors, wrap, abort.
module tb_hog_sos_window_gen;
    localparam int QN = 8, TW = 35, LANES = 4, MAX_COLS = 64, COL_AW = 7;

    logic                  aclk = 1'b0;
    logic                  arest, start, s_valid, s_ready, s_last, m_valid, m_ready, m_last;
    logic                  busy, done, cfg_err;
    logic [COL_AW-1:0]     cfg_cols;
    logic [7:0]            cfg_rows;
    logic [LANES*TW-1:0]   s_data;
    logic [LANES-1:0]      s_keep;
    logic [9*TW-1:0]       m_win;

    int n_checks = 0, n_bad = 0, done_cnt = 0;
    logic [9*TW-1:0] got_q[$];
    logic            got_last_q[$];
    logic [9*TW-1:0] exp_q[$];

    hog_sos_window_gen #(.QN(QN), .TOTAL_BIT_WIDTH(TW), .LANES(LANES), .MAX_COLS(MAX_COLS)) dut (
        .aclk(aclk), .arest(arest), .start(start), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_keep(s_keep), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_win(m_win), .m_last(m_last),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    // clock / reset
    always #5 aclk = ~aclk;

    // output monitor
    always @(negedge aclk) begin
        if (!arest && m_valid && m_ready) begin
            got_q.push_back(m_win);
            got_last_q.push_back(m_last);
        end
        if (done) done_cnt++;
    end

    // driver tasks
    function automatic logic [LANES*TW-1:0] lane0_beat(input int v);
        logic [LANES*TW-1:0] d;
        logic [TW-1:0] lv;
        d = '0;
        lv = TW'(v);
        d[TW-1:0] = lv << QN;
        d[2*TW-1:TW] = TW'(32'h1234);
        return d;
    endfunction

    task automatic pulse_start(input int rows, input int cols);
        @(posedge aclk); #1;
        start = 1'b1;
        cfg_rows = rows[7:0];
        cfg_cols = cols[COL_AW-1:0];
        @(posedge aclk); #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [LANES*TW-1:0] d, input logic [LANES-1:0] k,
                             input logic last, output bit ok);
        ok = 1'b0;
        s_valid = 1'b1; s_data = d; s_keep = k; s_last = last;
        for (int i = 0; i < 400; i++) begin
            @(negedge aclk);
            if (s_ready) begin ok = 1'b1; break; end
        end
        @(posedge aclk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic drive_frame(input int rows, input int cols, input int beats, input int kind,
                               input int off, output int timeouts);
        logic [LANES*TW-1:0] d;
        logic [LANES-1:0] k;
        logic [TW-1:0] lv;
        bit ok;
        timeouts = 0;
        for (int idx = 0; idx < rows*cols; idx++) begin
            for (int b = 0; b < beats; b++) begin
                if (kind == 0) begin
                    d = lane0_beat(idx + off);
                    k = 4'b0001;
                end else begin
                    lv = (kind == 1) ? (TW'(1) << QN) : '1;
                    for (int l = 0; l < LANES; l++) d[l*TW +: TW] = lv;
                    k = '1;
                end
                send_beat(d, k, (b == beats-1), ok);
                if (!ok) timeouts++;
            end
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge aclk);
            if (done) begin ok = 1'b1; break; end
        end
    endtask

    // scenarios
    task automatic test_reset();
        repeat (2) @(negedge aclk);
        n_checks++;
        if ({s_ready, m_valid, m_last, busy, done, cfg_err} !== 6'b0) begin
            n_bad++; $display("FAIL reset_flags: got %b want 000000", {s_ready, m_valid, m_last, busy, done, cfg_err});
        end
        n_checks++;
        if (m_win !== '0) begin n_bad++; $display("FAIL reset_win: got %0h want 0", m_win); end
        @(posedge aclk); #1;
        arest = 1'b0;
    endtask

    task automatic test_single_window();
        bit ok;
        int d0;
        logic [9*TW-1:0] w;
        got_q.delete(); got_last_q.delete(); exp_q.delete();
        d0 = done_cnt;
        pulse_start(3, 3);
        @(negedge aclk);
        n_checks++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_on: got %b want 1", busy); end
        @(posedge aclk); #1;
        for (int i = 0; i < 9; i++) begin
            send_beat(lane0_beat(i), 4'b0001, 1'b1, ok);
            n_checks++;
            if (!ok) begin n_bad++; $display("FAIL single_beat_timeout: got 0 want 1 (beat %0d)", i); end
        end
        @(negedge aclk);
        n_checks++;
        if (m_valid !== 1'b0) begin n_bad++; $display("FAIL single_lat_early: got %b want 0", m_valid); end
        @(negedge aclk);
        n_checks++;
        if (m_valid !== 1'b1) begin n_bad++; $display("FAIL single_lat_t2: got %b want 1", m_valid); end
        wait_done(ok);
        n_checks++;
        if (!ok) begin n_bad++; $display("FAIL single_done_timeout: got 0 want 1"); end
        for (int k = 0; k < 9; k++) w[k*TW +: TW] = TW'((k*k) << QN);
        exp_q.push_back(w);
        repeat (3) @(negedge aclk);
        n_checks++;
        if (got_q.size() !== 1) begin n_bad++; $display("FAIL single_count: got %0d want 1", got_q.size()); end
        if (got_q.size() >= 1) begin
            w = got_q[0];
            for (int k = 0; k < 9; k++) begin
                n_checks++;
                if (w[k*TW +: TW] !== exp_q[0][k*TW +: TW]) begin
                    n_bad++; $display("FAIL single_slot%0d: got %0h want %0h", k, w[k*TW +: TW], exp_q[0][k*TW +: TW]);
                end
            end
            n_checks++;
            if (got_last_q[0] !== 1'b1) begin n_bad++; $display("FAIL single_last: got %b want 1", got_last_q[0]); end
        end
        n_checks++;
        if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt - d0); end
        n_checks++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_off: got %b want 0", busy); end
    endtask

    task automatic test_multi_window();
        bit ok;
        int to;
        logic [9*TW-1:0] w;
        got_q.delete(); got_last_q.delete(); exp_q.delete();
        pulse_start(4, 5);
        drive_frame(4, 5, 2, 1, 0, to);
        n_checks++;
        if (to !== 0) begin n_bad++; $display("FAIL multi_timeouts: got %0d want 0", to); end
        wait_done(ok);
        n_checks++;
        if (!ok) begin n_bad++; $display("FAIL multi_done_timeout: got 0 want 1"); end
        for (int k = 0; k < 9; k++) w[k*TW +: TW] = TW'(8 << QN);
        n_checks++;
        if (got_q.size() !== 6) begin n_bad++; $display("FAIL multi_count: got %0d want 6", got_q.size()); end
        for (int j = 0; j < got_q.size() && j < 6; j++) begin
            n_checks++;
            if (got_q[j] !== w) begin n_bad++; $display("FAIL multi_win%0d: got %0h want %0h", j, got_q[j], w); end
            n_checks++;
            if (got_last_q[j] !== (j == 5)) begin
                n_bad++; $display("FAIL multi_last%0d: got %b want %b", j, got_last_q[j], (j == 5));
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int to;
        logic [9*TW-1:0] w;
        got_q.delete(); got_last_q.delete(); exp_q.delete();
        pulse_start(4, 4);
        fork
            drive_frame(4, 4, 1, 0, 1, to);
            begin
                bit seen, have;
                logic [9*TW-1:0] held;
                seen = 1'b0; have = 1'b0;
                for (int i = 0; i < 400 && got_q.size() == 0; i++) @(negedge aclk);
                n_checks++;
                if (got_q.size() == 0) begin n_bad++; $display("FAIL bp_first_win: got 0 want 1"); end
                @(posedge aclk); #1;
                m_ready = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    @(negedge aclk);
                    if (m_valid) begin
                        seen = 1'b1;
                        n_checks++;
                        if (s_ready !== 1'b0) begin n_bad++; $display("FAIL bp_s_ready: got %b want 0", s_ready); end
                        if (have) begin
                            n_checks++;
                            if (m_win !== held) begin n_bad++; $display("FAIL bp_stable: got %0h want %0h", m_win, held); end
                        end
                        held = m_win; have = 1'b1;
                    end
                end
                @(posedge aclk); #1;
                m_ready = 1'b1;
                n_checks++;
                if (!seen) begin n_bad++; $display("FAIL bp_stall_seen: got 0 want 1"); end
            end
        join
        n_checks++;
        if (to !== 0) begin n_bad++; $display("FAIL bp_timeouts: got %0d want 0", to); end
        wait_done(ok);
        n_checks++;
        if (!ok) begin n_bad++; $display("FAIL bp_done_timeout: got 0 want 1"); end
        for (int j = 0; j < 4; j++) begin
            for (int rr = 0; rr < 3; rr++)
                for (int cc = 0; cc < 3; cc++) begin
                    int c;
                    c = (j/2 + rr)*4 + (j%2) + cc + 1;
                    w[(rr*3+cc)*TW +: TW] = TW'((c*c) << QN);
                end
            exp_q.push_back(w);
        end
        n_checks++;
        if (got_q.size() !== 4) begin n_bad++; $display("FAIL bp_count: got %0d want 4", got_q.size()); end
        for (int j = 0; j < got_q.size() && j < 4; j++) begin
            n_checks++;
            if (got_q[j] !== exp_q[j]) begin n_bad++; $display("FAIL bp_win%0d: got %0h want %0h", j, got_q[j], exp_q[j]); end
            n_checks++;
            if (got_last_q[j] !== (j == 3)) begin n_bad++; $display("FAIL bp_last%0d: got %b want %b", j, got_last_q[j], (j == 3)); end
        end
    endtask

    task automatic test_cfg_err();
        bit ok;
        int to, d0;
        int bad_rows[3] = '{3, 3, 2};
        int bad_cols[3] = '{2, MAX_COLS + 1, 5};
        logic [9*TW-1:0] w;
        for (int i = 0; i < 3; i++) begin
            pulse_start(bad_rows[i], bad_cols[i]);
            @(negedge aclk);
            n_checks++;
            if ({cfg_err, busy} !== 2'b10) begin
                n_bad++; $display("FAIL cfgerr_pulse%0d: got err,busy=%b want 10", i, {cfg_err, busy});
            end
            @(negedge aclk);
            n_checks++;
            if ({cfg_err, busy} !== 2'b00) begin
                n_bad++; $display("FAIL cfgerr_clear%0d: got err,busy=%b want 00", i, {cfg_err, busy});
            end
        end
        got_q.delete(); got_last_q.delete();
        d0 = done_cnt;
        pulse_start(3, 3);
        pulse_start(3, 2);
        @(negedge aclk);
        n_checks++;
        if ({cfg_err, busy} !== 2'b01) begin
            n_bad++; $display("FAIL cfgerr_busy_start: got err,busy=%b want 01", {cfg_err, busy});
        end
        @(posedge aclk); #1;
        drive_frame(3, 3, 1, 0, 0, to);
        wait_done(ok);
        n_checks++;
        if (!ok || to !== 0) begin n_bad++; $display("FAIL cfgerr_frame: got ok=%0d to=%0d want ok=1 to=0", ok, to); end
        for (int k = 0; k < 9; k++) w[k*TW +: TW] = TW'((k*k) << QN);
        repeat (2) @(negedge aclk);
        n_checks++;
        if (got_q.size() !== 1) begin n_bad++; $display("FAIL cfgerr_count: got %0d want 1", got_q.size()); end
        else begin
            n_checks++;
            if (got_q[0] !== w) begin n_bad++; $display("FAIL cfgerr_win: got %0h want %0h", got_q[0], w); end
        end
        n_checks++;
        if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL cfgerr_done_cnt: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_wrap();
        bit ok;
        int to;
        logic [TW-1:0] slot;
        logic [9*TW-1:0] w;
        got_q.delete(); got_last_q.delete();
`ifdef SOS_SAT_EN
        slot = '1;
`else
        slot = 35'h7C000_0000;
`endif
        for (int k = 0; k < 9; k++) w[k*TW +: TW] = slot;
        pulse_start(3, 3);
        drive_frame(3, 3, 1, 2, 0, to);
        wait_done(ok);
        n_checks++;
        if (!ok || to !== 0) begin n_bad++; $display("FAIL wrap_frame: got ok=%0d to=%0d want ok=1 to=0", ok, to); end
        repeat (2) @(negedge aclk);
        n_checks++;
        if (got_q.size() !== 1) begin n_bad++; $display("FAIL wrap_count: got %0d want 1", got_q.size()); end
        else begin
            n_checks++;
            if (got_q[0] !== w) begin n_bad++; $display("FAIL wrap_win: got %0h want %0h", got_q[0], w); end
            n_checks++;
            if (got_last_q[0] !== 1'b1) begin n_bad++; $display("FAIL wrap_last: got %b want 1", got_last_q[0]); end
        end
    endtask

    task automatic test_abort();
        bit ok;
        int to, d0;
        logic [9*TW-1:0] w;
        d0 = done_cnt;
        pulse_start(3, 3);
        for (int i = 0; i < 4; i++) send_beat(lane0_beat(i), 4'b0001, 1'b1, ok);
        arest = 1'b1;
        @(negedge aclk);
        n_checks++;
        if ({s_ready, m_valid, m_last, busy, done, cfg_err} !== 6'b0 || m_win !== '0) begin
            n_bad++; $display("FAIL abort_outputs: got %b win %0h want 000000 win 0",
                              {s_ready, m_valid, m_last, busy, done, cfg_err}, m_win);
        end
        repeat (3) @(posedge aclk);
        #1 arest = 1'b0;
        repeat (5) @(negedge aclk);
        n_checks++;
        if (done_cnt !== d0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL abort_no_done: got done_cnt=%0d busy=%b want %0d 0", done_cnt - d0, busy, 0);
        end
        got_q.delete(); got_last_q.delete();
        pulse_start(3, 3);
        drive_frame(3, 3, 1, 0, 2, to);
        wait_done(ok);
        n_checks++;
        if (!ok || to !== 0) begin n_bad++; $display("FAIL abort_restart: got ok=%0d to=%0d want ok=1 to=0", ok, to); end
        for (int k = 0; k < 9; k++) w[k*TW +: TW] = TW'(((k+2)*(k+2)) << QN);
        repeat (2) @(negedge aclk);
        n_checks++;
        if (got_q.size() !== 1) begin n_bad++; $display("FAIL abort_count: got %0d want 1", got_q.size()); end
        else begin
            n_checks++;
            if (got_q[0] !== w) begin n_bad++; $display("FAIL abort_win: got %0h want %0h", got_q[0], w); end
        end
        n_checks++;
        if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL abort_done_cnt: got %0d want 1", done_cnt - d0); end
    endtask

    initial begin
        arest = 1'b1; start = 1'b0; cfg_cols = '0; cfg_rows = '0;
        s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0; m_ready = 1'b1;
        test_reset();
        test_single_window();
        test_multi_window();
        test_backpressure();
        test_cfg_err();
        test_wrap();
        test_abort();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
